btn_debouncer_multi: RTL and testbench
======================================

# btn_debouncer_multi

Parametrised multi-channel button conditioner that replaces single-channel `btn_debouncer` instances on the board's user inputs. Each channel:
- synchronises a raw pad signal into `clk` and corrects its polarity;
- debounces it with a time-based stability filter;
- emits one-cycle press, release and auto-repeat event pulses.

It sits between the input pads and the game/control logic, so downstream logic consumes clean levels and single-cycle events only.

## Interface
Parameters:
- `CLKIN_FREQ`, 27000000, clock frequency in Hz.
- `DEBOUNCE_PERIOD`, 10e-3, required stability time in seconds (real). D = max(1, round(CLKIN_FREQ*DEBOUNCE_PERIOD)).
- `NUM_BTNS`, 4, channel count (1..32).
- `ACTIVE_LOW`, 1, when 1, a pressed button drives 0 on `noisyIn`. The input is inverted before synchronisation.
- `REPEAT_DELAY`, 0.5, seconds from press to the first repeat (real). R_D = round(CLKIN_FREQ*REPEAT_DELAY). 0 disables repeat.
- `REPEAT_RATE`, 0.1, seconds between subsequent repeats (real). R_R = max(1, round(CLKIN_FREQ*REPEAT_RATE)).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `noisyIn`  in  NUM_BTNS  raw pad inputs, asynchronous to `clk`.
- `debounceOut`  out  NUM_BTNS  debounced level, 1 = pressed (after polarity correction).
- `pressPulse`  out  NUM_BTNS  one-cycle pulse on each debounced press.
- `releasePulse`  out  NUM_BTNS  one-cycle pulse on each debounced release.
- `repeatPulse`  out  NUM_BTNS  one-cycle auto-repeat pulses while a channel is held.

## Operation
**Per-channel pipeline:** polarity correction, then 2-FF synchroniser (`s0`, `s1`), then stability counter, then event/repeat FSM. Channels are fully independent; there is no shared arbitration.

**Stability counter:** `cnt` is ceil(log2(D+1)) bits. Each rising edge:
- if `s1 != debounceOut`:
  - if `cnt == D-1`: `debounceOut <= s1`, `cnt <= 0`;
  - else `cnt <= cnt+1`.
- else `cnt <= 0`. Any bounce back to the stable level restarts the count.

**Event pulses:** all outputs are registered.
- `pressPulse` is set on the same edge that `debounceOut` goes 0→1.
- `releasePulse` is set on the same edge that `debounceOut` goes 1→0.
- Each pulse is high for exactly one cycle.

**Repeat FSM:** states RELEASED, HOLD_DELAY, HOLD_REPEAT, with repeat counter `rcnt` sized for max(R_D, R_R).
- RELEASED → HOLD_DELAY on the press edge, with `rcnt <= 0`. This transition is taken only if R_D > 0; otherwise the FSM stays in RELEASED.
- HOLD_DELAY: `rcnt` increments each cycle. At `rcnt == R_D-1`: `repeatPulse` asserts, `rcnt <= 0`, next state HOLD_REPEAT.
- HOLD_REPEAT: at `rcnt == R_R-1`: `repeatPulse` asserts, `rcnt <= 0`.
- Any state → RELEASED on the release edge. `repeatPulse` is never asserted in the release cycle.
- `repeatPulse` and `pressPulse` are never high in the same cycle.

## Timing
**Reset (`reset` low):** all of the following go to 0 immediately and asynchronously:
- `s0`, `s1`, `cnt`, `rcnt`;
- `debounceOut`, `pressPulse`, `releasePulse`, `repeatPulse`.

The FSM enters RELEASED. Because the synchroniser resets to the released level, an input held released after reset produces no event.

**Press latency:** if the corrected input changes before edge k and then holds, `debounceOut` and the event pulse change at edge k+1+D. Example: D=3 gives edge k+4.

**Glitch rejection:** any excursion lasting fewer than D consecutive `s1` cycles produces no output change.

**Repeat cadence:** with the press pulse in cycle P, repeat pulses occur in cycles P+R_D, P+R_D+R_R, P+R_D+2R_R, and so on.

**Reset mid-operation:**
- A held button asserts no `releasePulse`.
- After reset deasserts while the button is still held, a fresh press (including `pressPulse`) follows after 2+D cycles.

**Wrap-around:** counters never wrap. Each counter clears exactly at its terminal value.

## Test plan
Common configuration: CLKIN_FREQ=27e6, DEBOUNCE_PERIOD=100e-9 (D=3), REPEAT_DELAY=1e-6 (R_D=27), REPEAT_RATE=370e-9 (R_R=10), NUM_BTNS=4, ACTIVE_LOW=1.

- **Reset:** hold `reset`=0 for 100 ns with `noisyIn` random, then release with `noisyIn`=4'hF → all outputs 0 throughout, and no pulses for 50 cycles.
- **Clean press:** `noisyIn[0]` 1→0 before edge k → `debounceOut[0]`=1 and `pressPulse[0]`=1 at edge k+4. `pressPulse[0]` drops at k+5. Channels 1..3 stay 0.
- **Glitches:** a 2-cycle low pulse on `noisyIn[1]`, then `noisyIn[1]` toggling every cycle for 100 cycles → no output change and no pulses on channel 1.
- **Hold and repeat:** hold channel 2 pressed for 80 cycles after its press pulse at cycle P → `repeatPulse[2]` in cycles P+27, P+37, P+47, P+57, P+67, P+77. On release, `releasePulse[2]` fires once 4 cycles later and repeats stop.
- **Simultaneous events and reset:** press all four channels on the same edge → all four `pressPulse` bits high in the same single cycle. Then assert `reset` mid-hold → outputs 0 immediately, with no `releasePulse`.
- **Random stimulus:** `noisyIn` re-randomised every 60 ns for 10 µs, with a scoreboard model → every `debounceOut` transition is preceded by D stable `s1` cycles, and pulse counts match the model exactly.

Source files
------------

// File: rtl/btn_debouncer_multi.sv
`timescale 1ns/1ps
// btn_debouncer_multi
// Multi-channel button conditioner. Each channel corrects the pad polarity,
// synchronises it into clk, filters it with a time-based stability counter
// and produces registered press, release and auto-repeat pulses.
// All channels are independent copies of the same pipeline.

module btn_debouncer_multi #(
    parameter int  CLKIN_FREQ      = 27000000,
    parameter real DEBOUNCE_PERIOD = 10e-3,
    parameter int  NUM_BTNS        = 4,
    parameter int  ACTIVE_LOW      = 1,
    parameter real REPEAT_DELAY    = 0.5,
    parameter real REPEAT_RATE     = 0.1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] noisyIn,
    output logic [NUM_BTNS-1:0] debounceOut,
    output logic [NUM_BTNS-1:0] pressPulse,
    output logic [NUM_BTNS-1:0] releasePulse,
    output logic [NUM_BTNS-1:0] repeatPulse
);

    // Cycle counts derived from the real-valued time parameters (rounded).
    localparam int D_RAW  = $rtoi(CLKIN_FREQ * DEBOUNCE_PERIOD + 0.5);
    localparam int RD_RAW = $rtoi(CLKIN_FREQ * REPEAT_DELAY + 0.5);
    localparam int RR_RAW = $rtoi(CLKIN_FREQ * REPEAT_RATE + 0.5);

    // A zero debounce time still needs one confirming cycle, a zero repeat
    // delay disables repeat, and the repeat rate is at least one cycle.
    localparam int D    = (D_RAW < 1) ? 1 : D_RAW;
    localparam int RD   = (RD_RAW < 0) ? 0 : RD_RAW;
    localparam int RR   = (RR_RAW < 1) ? 1 : RR_RAW;
    localparam int RMAX = (RD > RR) ? RD : RR;

    localparam int CNT_W  = (D > 1)    ? $clog2(D + 1)    : 1;
    localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

    // Terminal values at which the counters clear instead of incrementing.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(D - 1);
    localparam logic [RCNT_W-1:0] RD_LAST  = RCNT_W'((RD > 0) ? (RD - 1) : 0);
    localparam logic [RCNT_W-1:0] RR_LAST  = RCNT_W'(RR - 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } repeatState_t;

    // Polarity correction happens before the synchroniser so that every
    // internal signal uses 1 = pressed.
    logic [NUM_BTNS-1:0] w_corrected;
    assign w_corrected = (ACTIVE_LOW != 0) ? ~noisyIn : noisyIn;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : gChan

        logic               r_s0;
        logic               r_s1;
        logic               r_level;
        logic [CNT_W-1:0]   r_cnt;
        logic               r_press;
        logic               r_release;
        logic               r_repeat;
        logic [RCNT_W-1:0]  r_rcnt;
        repeatState_t       r_state;

        logic               w_mismatch;
        logic               w_settle;
        logic               w_pressEv;
        logic               w_releaseEv;
        repeatState_t       w_stateNext;
        logic [RCNT_W-1:0]  w_rcntNext;
        logic               w_repeatNext;

        // Two-flop synchroniser; resets to the released level so a button
        // that is idle across reset produces no spurious event.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_s0 <= 1'b0;
                r_s1 <= 1'b0;
            end else begin
                r_s0 <= w_corrected[g];
                r_s1 <= r_s0;
            end
        end

        // The level flips on the edge where the synchronised input has
        // disagreed with it for D consecutive cycles.
        assign w_mismatch  = (r_s1 != r_level);
        assign w_settle    = w_mismatch && (r_cnt == CNT_LAST);
        assign w_pressEv   = w_settle && r_s1;
        assign w_releaseEv = w_settle && !r_s1;

        // Stability counter: counts disagreeing cycles and restarts on any
        // bounce back to the current level.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (w_mismatch) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_s1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        // Press and release pulses are registered on the same edge the
        // debounced level changes, so they line up with it exactly.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_pressEv;
                r_release <= w_releaseEv;
            end
        end

        // Repeat FSM state, repeat counter and registered repeat pulse.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state  <= RELEASED;
                r_rcnt   <= '0;
                r_repeat <= 1'b0;
            end else begin
                r_state  <= w_stateNext;
                r_rcnt   <= w_rcntNext;
                r_repeat <= w_repeatNext;
            end
        end

        // Repeat FSM next state: the first repeat comes RD cycles after the
        // press, later ones every RR cycles; release overrides everything so
        // no repeat is emitted in the release cycle.
        always_comb begin
            w_stateNext  = r_state;
            w_rcntNext   = r_rcnt;
            w_repeatNext = 1'b0;
            case (r_state)
                RELEASED: begin
                    if (w_pressEv && (RD > 0)) begin
                        w_stateNext = HOLD_DELAY;
                        w_rcntNext  = '0;
                    end
                end
                HOLD_DELAY: begin
                    if (r_rcnt == RD_LAST) begin
                        w_repeatNext = 1'b1;
                        w_rcntNext   = '0;
                        w_stateNext  = HOLD_REPEAT;
                    end else begin
                        w_rcntNext = r_rcnt + 1'b1;
                    end
                end
                HOLD_REPEAT: begin
                    if (r_rcnt == RR_LAST) begin
                        w_repeatNext = 1'b1;
                        w_rcntNext   = '0;
                    end else begin
                        w_rcntNext = r_rcnt + 1'b1;
                    end
                end
                default: begin
                    w_stateNext = RELEASED;
                    w_rcntNext  = '0;
                end
            endcase
            if (w_releaseEv) begin
                w_stateNext  = RELEASED;
                w_rcntNext   = '0;
                w_repeatNext = 1'b0;
            end
        end

        assign debounceOut[g]  = r_level;
        assign pressPulse[g]   = r_press;
        assign releasePulse[g] = r_release;
        assign repeatPulse[g]  = r_repeat;

    end : gChan

endmodule

// File: tb/tb_btn_debouncer_multi.sv
`timescale 1ns/1ps
// Testbench for btn_debouncer_multi: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.

module tb_btn_debouncer_multi;

    localparam int NB = 4;
    localparam int D  = 3;
    localparam int RD = 27;
    localparam int RR = 10;

    logic          clk;
    logic          reset;
    logic [NB-1:0] noisyIn;
    logic [NB-1:0] debounceOut;
    logic [NB-1:0] pressPulse;
    logic [NB-1:0] releasePulse;
    logic [NB-1:0] repeatPulse;

    int errors;
    int checks;

    btn_debouncer_multi #(
        .CLKIN_FREQ      (27000000),
        .DEBOUNCE_PERIOD (100e-9),
        .NUM_BTNS        (NB),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (1e-6),
        .REPEAT_RATE     (370e-9)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .noisyIn      (noisyIn),
        .debounceOut  (debounceOut),
        .pressPulse   (pressPulse),
        .releasePulse (releasePulse),
        .repeatPulse  (repeatPulse)
    );

    // 100 MHz simulation clock; the debouncer only sees cycle counts.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive a new pad value just after a rising edge, so it is first
    // sampled on the following edge.
    task automatic applyStimulus(input logic [NB-1:0] value);
        @(posedge clk);
        #1;
        noisyIn = value;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural model. hist holds the corrected pad value sampled on each
    // edge; the synchronised value seen on edge n is the one sampled two
    // edges earlier. The level flips when the last D synchronised values
    // all differ from it. Repeats are scheduled from the press edge.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] mDb, mPress, mRel, mRep;
    logic [NB-1:0] prevDb;
    int            pressEdge[NB];
    int            edgeCnt;
    int            since;
    bit            allOpp;
    int            dutPressTot, dutRelTot, dutRepTot;
    int            mPressTot, mRelTot, mRepTot;

    initial begin
        mDb = '0; mPress = '0; mRel = '0; mRep = '0; edgeCnt = 0;
        dutPressTot = 0; dutRelTot = 0; dutRepTot = 0;
        mPressTot = 0; mRelTot = 0; mRepTot = 0;
        errors = 0; checks = 0;
    end

    // Model update and per-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            hist.delete();
            for (int i = 0; i < D + 2; i++) hist.push_back('0);
            mDb = '0; mPress = '0; mRel = '0; mRep = '0;
            edgeCnt = 0;
        end else begin
            edgeCnt++;
            prevDb = mDb;
            for (int c = 0; c < NB; c++) begin
                allOpp = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[hist.size() - 3 - j][c] == prevDb[c]) allOpp = 1'b0;
                if (allOpp) mDb[c] = ~prevDb[c];
            end
            mPress = mDb & ~prevDb;
            mRel   = ~mDb & prevDb;
            for (int c = 0; c < NB; c++) begin
                if (mPress[c]) pressEdge[c] = edgeCnt;
                since = edgeCnt - pressEdge[c];
                mRep[c] = (RD > 0) && mDb[c] && prevDb[c] && (since >= RD)
                          && (((since - RD) % RR) == 0);
            end
        end
        checkOutput("debounceOut", debounceOut, mDb);
        checkOutput("pressPulse", pressPulse, mPress);
        checkOutput("releasePulse", releasePulse, mRel);
        checkOutput("repeatPulse", repeatPulse, mRep);
        dutPressTot += $countones(pressPulse);
        dutRelTot   += $countones(releasePulse);
        dutRepTot   += $countones(repeatPulse);
        mPressTot   += $countones(mPress);
        mRelTot     += $countones(mRel);
        mRepTot     += $countones(mRep);
        hist.push_back(~noisyIn);
        if (hist.size() > D + 4) void'(hist.pop_front());
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200us;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int idle;
        int ch1Act;
        int found;
        int repOffs[$];
        int expOffs[6];
        int relCnt, relOff, repAfter, relSum;

        reset   = 1'b0;
        noisyIn = 4'($urandom);
        expOffs = '{27, 37, 47, 57, 67, 77};

        // Reset held with random pads, then released with all buttons up.
        repeat (10) applyStimulus(4'($urandom));
        checkOutput("resetOutputs",
                    {debounceOut, pressPulse, releasePulse, repeatPulse}, 0);
        applyStimulus(4'hF);
        @(negedge clk);
        #1;
        reset = 1'b1;
        idle = 0;
        for (int i = 0; i < 50; i++) begin
            waitEdges(1);
            idle += $countones({debounceOut, pressPulse, releasePulse, repeatPulse});
        end
        checkOutput("idleAfterReset", idle, 0);

        // Clean press on channel 0: level and pulse at edge k+4.
        applyStimulus(4'hE);
        waitEdges(4);
        checkOutput("press0Early", debounceOut, 4'h0);
        waitEdges(1);
        checkOutput("press0Level", debounceOut, 4'h1);
        checkOutput("press0Pulse", pressPulse, 4'h1);
        @(negedge clk);
        #1;
        checkOutput("modelPress0", mPress, 4'h1);
        waitEdges(1);
        checkOutput("press0Drop", pressPulse, 4'h0);
        checkOutput("press0Hold", debounceOut, 4'h1);

        // Glitches on channel 1: 2-cycle press, then toggling every cycle.
        ch1Act = 0;
        applyStimulus(4'hC);
        ch1Act += debounceOut[1] | pressPulse[1] | releasePulse[1] | repeatPulse[1];
        applyStimulus(4'hC);
        ch1Act += debounceOut[1] | pressPulse[1] | releasePulse[1] | repeatPulse[1];
        applyStimulus(4'hE);
        ch1Act += debounceOut[1] | pressPulse[1] | releasePulse[1] | repeatPulse[1];
        for (int i = 0; i < 100; i++) begin
            applyStimulus(((i % 2) == 0) ? 4'hC : 4'hE);
            ch1Act += debounceOut[1] | pressPulse[1] | releasePulse[1] | repeatPulse[1];
        end
        for (int i = 0; i < 6; i++) begin
            waitEdges(1);
            ch1Act += debounceOut[1] | pressPulse[1] | releasePulse[1] | repeatPulse[1];
        end
        checkOutput("glitch1Activity", ch1Act, 0);

        // Hold channel 2 and record repeat offsets relative to its press.
        applyStimulus(4'hA);
        found = -1;
        for (int i = 0; i < 20; i++) begin
            waitEdges(1);
            if (pressPulse[2] && found < 0) begin
                found = i;
                break;
            end
        end
        checkOutput("press2Latency", found, 4);
        for (int off = 1; off <= 80; off++) begin
            waitEdges(1);
            if (repeatPulse[2]) repOffs.push_back(off);
        end
        checkOutput("repeat2Count", repOffs.size(), 6);
        for (int j = 0; j < 6; j++)
            checkOutput("repeat2Offset", (repOffs.size() > j) ? repOffs[j] : -1, expOffs[j]);
        applyStimulus(4'hE);
        relCnt = 0; relOff = -1; repAfter = 0;
        for (int off = 0; off < 20; off++) begin
            waitEdges(1);
            if (releasePulse[2]) begin
                relCnt++;
                relOff = off;
            end
            if (repeatPulse[2]) repAfter++;
        end
        checkOutput("release2Count", relCnt, 1);
        checkOutput("release2Latency", relOff, 4);
        checkOutput("repeat2AfterRelease", repAfter, 0);

        // Simultaneous press of every channel, then reset while held.
        applyStimulus(4'hF);
        waitEdges(10);
        applyStimulus(4'h0);
        waitEdges(4);
        checkOutput("allPressEarly", pressPulse, 4'h0);
        waitEdges(1);
        checkOutput("allPress", pressPulse, 4'hF);
        @(negedge clk);
        #1;
        checkOutput("modelAllPress", mPress, 4'hF);
        waitEdges(1);
        checkOutput("allPressDrop", pressPulse, 4'h0);
        waitEdges(5);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("resetImmediate",
                    {debounceOut, pressPulse, releasePulse, repeatPulse}, 0);
        relSum = 0;
        for (int i = 0; i < 3; i++) begin
            waitEdges(1);
            relSum += $countones(releasePulse);
        end
        checkOutput("noReleaseOnReset", relSum, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        found = -1;
        for (int i = 0; i < 20; i++) begin
            waitEdges(1);
            if (pressPulse == 4'hF && found < 0) begin
                found = i;
                break;
            end
        end
        checkOutput("pressAfterReset", found, 1 + D);

        // Random pads, a new value every 60 ns for 10 us.
        for (int i = 0; i < 167; i++) begin
            applyStimulus(4'($urandom));
            repeat (5) @(posedge clk);
        end
        applyStimulus(4'hF);
        waitEdges(40);
        checkOutput("pressTotal", dutPressTot, mPressTot);
        checkOutput("releaseTotal", dutRelTot, mRelTot);
        checkOutput("repeatTotal", dutRepTot, mRepTot);
        checkOutput("finalLevel", debounceOut, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
